// File: rtl/bp_cce_resource_arbiter.sv
// bp_cce_resource_arbiter
//
// N-way arbiter in front of a shared CCE resource (directory, pending bits,
// speculative bits). Each cycle one requester is chosen under round-robin
// (rr_p=1) or fixed priority (rr_p=0, requester 0 highest). The winner's
// payload is captured into a one-entry output register that is drained with
// a valid/yumi handshake. A requester may lock the grant across several
// transfers for multi-beat operations.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      asynchronous, active-high reset
//   req_v_i      per-requester valid
//   req_lock_i   per-requester lock request, sampled on transfer
//   req_data_i   packed payloads, requester i at [i*data_width_p +: data_width_p]
//   req_ready_o  one-hot-or-zero grant; transfer = req_v_i[i] & req_ready_o[i]
//   v_o          output register holds a request
//   data_o       registered payload
//   id_o         index of the requester that owns data_o
//   yumi_i       consumer dequeues the output this cycle (only while v_o=1)
module bp_cce_resource_arbiter #(
  parameter int num_req_p    = 2,
  parameter int data_width_p = 64,
  parameter bit rr_p         = 1'b1,
  parameter int id_width_p   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p-1:0]              req_lock_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_ready_o,
  output logic                              v_o,
  output logic [data_width_p-1:0]           data_o,
  output logic [id_width_p-1:0]             id_o,
  input  logic                              yumi_i
);

  logic [id_width_p-1:0]   ptr;
  logic                    locked;
  logic [id_width_p-1:0]   lock_id;

  logic                    accept;
  logic                    grant_v;
  logic [id_width_p-1:0]   grant_id;
  logic [id_width_p-1:0]   scan_id;
  logic [data_width_p-1:0] grant_data;
  logic [id_width_p-1:0]   next_ptr;
  logic                    xfer;
  logic                    grant_lock;

  // The output slot can take a new request when empty or being drained now.
  assign accept = ~v_o | yumi_i;

  // ---- Stage 0: combinational grant selection ----
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    scan_id  = '0;
    if (locked) begin
      // Only the lock owner may be granted; if it drops valid, everyone stalls.
      grant_v  = req_v_i[lock_id];
      grant_id = lock_id;
    end else if (rr_p) begin
      // Scan upward from ptr with wrap; first valid requester wins.
      for (int k = 0; k < num_req_p; k++) begin
        scan_id = id_width_p'((int'(ptr) + k) % num_req_p);
        if (!grant_v && req_v_i[scan_id]) begin
          grant_v  = 1'b1;
          grant_id = scan_id;
        end
      end
    end else begin
      // Descending scan so the lowest valid index is the last to assign.
      for (int k = num_req_p - 1; k >= 0; k--) begin
        if (req_v_i[k]) begin
          grant_v  = 1'b1;
          grant_id = id_width_p'(k);
        end
      end
    end
  end

  // Payload mux is only used by the register; no combinational path to outputs.
  always_comb begin
    grant_data = '0;
    grant_lock = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      if (grant_id == id_width_p'(k)) begin
        grant_data = req_data_i[k*data_width_p +: data_width_p];
        grant_lock = req_lock_i[k];
      end
    end
  end

  assign next_ptr = (int'(grant_id) == num_req_p - 1) ? '0 : grant_id + 1'b1;
  assign xfer     = accept & grant_v & ~reset_i;

  always_comb begin
    req_ready_o = '0;
    if (xfer) req_ready_o[grant_id] = 1'b1;
  end

  // ---- Stage 1: output register and arbitration state ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_o     <= 1'b0;
      data_o  <= '0;
      id_o    <= '0;
      ptr     <= '0;
      locked  <= 1'b0;
      lock_id <= '0;
    end else begin
      if (xfer) begin
        v_o    <= 1'b1;
        data_o <= grant_data;
        id_o   <= grant_id;
        // A transfer with lock=0 both releases an active lock and lets the
        // round-robin pointer move past the winner.
        locked <= grant_lock;
        if (grant_lock) lock_id <= grant_id;
        if (rr_p && !grant_lock) ptr <= next_ptr;
      end else if (yumi_i) begin
        v_o <= 1'b0;
      end
    end
  end

endmodule
